// File: rtl/fp_normpack.sv
`timescale 1ns/1ps
// fp_normpack: two-stage exponent adjust/classify then IEEE-754 single pack; define FP_SUBNORM_EN to pack underflow as subnormal
module fp_normpack (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [7:0]  in_exp,
  input  logic [7:0]  in_num,
  input  logic [23:0] in_res,
  input  logic        in_nan,
  input  logic        in_inf,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_f,
  output logic        out_of,
  output logic        out_uf
);
  typedef enum logic [2:0] {C_NORM, C_NAN, C_INF, C_ZERO, C_OF, C_UF} cls_t;
`ifdef FP_SUBNORM_EN
  localparam int RW = 24;
`else
  localparam int RW = 23;
`endif
  logic              s1_valid, s1_sign, s1_adv, s2_adv;
  logic signed [9:0] s1_e, e;
  logic [RW-1:0]     s1_res;
  cls_t              s1_cls, cls;
  logic [31:0]       sub_f, pack_f;
`ifdef FP_SUBNORM_EN
  logic signed [9:0] sh;
`endif
  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;
  // Adjust the exponent for the normalizer shift and classify the beat by priority
  always_comb begin
    e   = signed'((in_num == 8'hFF) ? {2'b0, in_exp} + 10'd1 : {2'b0, in_exp} - {2'b0, in_num});
    cls = in_nan ? C_NAN : in_inf ? C_INF : (in_res == 24'd0) ? C_ZERO :
          (e >= 10'sd255) ? C_OF : (e <= 10'sd0) ? C_UF : C_NORM;
  end
  // Stage 1 register: holds classified beat until stage 2 can take it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_e     <= '0;
      s1_res   <= '0;
      s1_cls   <= C_NORM;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sign <= in_sign;
        s1_e    <= e;
        s1_res  <= in_res[RW-1:0];
        s1_cls  <= cls;
      end
    end
  end
  // Underflow packing: denormalize by 1-e, or flush with sign kept
`ifdef FP_SUBNORM_EN
  always_comb begin
    sh    = 10'sd1 - s1_e;
    sub_f = (sh >= 10'sd24) ? 32'h0 : {s1_sign, 8'h00, 23'(s1_res >> sh[4:0])};
  end
`else
  assign sub_f = {s1_sign, 31'b0};
`endif
  // Select the packed word for the stage-1 class
  always_comb begin
    pack_f = (s1_cls == C_NAN) ? 32'h7FC00000 :
             (s1_cls == C_INF || s1_cls == C_OF) ? {s1_sign, 8'hFF, 23'd0} :
             (s1_cls == C_ZERO) ? 32'h0 :
             (s1_cls == C_UF) ? sub_f : {s1_sign, s1_e[7:0], s1_res[22:0]};
  end
  // Stage 2 output register: holds steady while downstream stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_f     <= 32'h0;
      out_of    <= 1'b0;
      out_uf    <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_f  <= pack_f;
        out_of <= s1_cls == C_OF;
        out_uf <= s1_cls == C_UF;
      end
    end
  end
endmodule

// File: tb/tb_fp_normpack.sv
`timescale 1ns/1ps
// tb_fp_normpack: directed checks of classification, packing, latency, back-pressure and reset
module tb_fp_normpack;
`ifdef FP_SUBNORM_EN
  localparam bit SUB = 1'b1;
`else
  localparam bit SUB = 1'b0;
`endif
  logic clk = 0, rst_n = 0, in_valid = 0, in_sign = 0, in_nan = 0, in_inf = 0, out_ready = 1;
  logic [7:0] in_exp = 0, in_num = 0;
  logic [23:0] in_res = 0;
  logic in_ready, out_valid, out_of, out_uf, early;
  logic [31:0] out_f;
  int errors = 0, checks = 0;
  typedef struct packed {
    logic s; logic [7:0] e; logic [7:0] n; logic [23:0] r; logic nan; logic inf;
    logic [31:0] f; logic of; logic uf;
  } vec_t;

  always #5 clk = ~clk;

  fp_normpack dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_num(in_num), .in_res(in_res),
    .in_nan(in_nan), .in_inf(in_inf), .out_valid(out_valid), .out_ready(out_ready),
    .out_f(out_f), .out_of(out_of), .out_uf(out_uf)
  );

  function automatic vec_t mk(input logic s, input logic [7:0] e, input logic [7:0] n,
                              input logic [23:0] r, input logic nan, input logic inf,
                              input logic [31:0] f, input logic of, input logic uf);
    return {s, e, n, r, nan, inf, f, of, uf};
  endfunction

  task automatic send(input vec_t v);
    in_sign = v.s; in_exp = v.e; in_num = v.n; in_res = v.r; in_nan = v.nan; in_inf = v.inf;
    in_valid = 1; out_ready = 1;
    @(posedge clk); #1 in_valid = 0;
    early = out_valid;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    in_valid = 1; in_exp = 8'h40; in_res = 24'h800000;
    repeat (2) @(negedge clk);
    checks++;
    if ({out_valid, out_f, out_of, out_uf} !== 35'h0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b f=%h of=%b uf=%b, expected all 0", out_valid, out_f, out_of, out_uf);
    end
    in_valid = 0;
    rst_n = 1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got in_ready=%b out_valid=%b, expected 1 and 0", in_ready, out_valid);
    end
  endtask

  task automatic test_normal;
    vec_t v [4];
    v[0] = mk(0, 8'h80, 8'hFF, 24'hC00000, 0, 0, 32'h40C00000, 0, 0);
    v[1] = mk(1, 8'h7F, 8'h03, 24'h800000, 0, 0, 32'hBE000000, 0, 0);
    v[2] = mk(0, 8'hFE, 8'h00, 24'hABCDEF, 0, 0, 32'h7F2BCDEF, 0, 0);
    v[3] = mk(0, 8'h01, 8'h00, 24'h800001, 0, 0, 32'h00800001, 0, 0);
    foreach (v[i]) begin
      send(v[i]);
      checks++;
      if (early !== 1'b0 || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL normal[%0d]_latency: got valid %b then %b, expected 0 then 1", i, early, out_valid);
      end
      checks++;
      if ({out_f, out_of, out_uf} !== {v[i].f, v[i].of, v[i].uf}) begin
        errors++;
        $display("FAIL normal[%0d]: got f=%h of=%b uf=%b, expected f=%h of=%b uf=%b", i, out_f, out_of, out_uf, v[i].f, v[i].of, v[i].uf);
      end
    end
  endtask

  task automatic test_special;
    vec_t v [4];
    v[0] = mk(1, 8'h10, 8'h00, 24'h000000, 0, 0, 32'h00000000, 0, 0);
    v[1] = mk(1, 8'hFE, 8'hFF, 24'h000000, 1, 1, 32'h7FC00000, 0, 0);
    v[2] = mk(1, 8'h00, 8'h00, 24'h000000, 0, 1, 32'hFF800000, 0, 0);
    v[3] = mk(0, 8'hFE, 8'hFF, 24'h000000, 0, 0, 32'h00000000, 0, 0);
    foreach (v[i]) begin
      send(v[i]);
      checks++;
      if (out_valid !== 1'b1 || {out_f, out_of, out_uf} !== {v[i].f, v[i].of, v[i].uf}) begin
        errors++;
        $display("FAIL special[%0d]: got valid=%b f=%h of=%b uf=%b, expected valid=1 f=%h of=%b uf=%b", i, out_valid, out_f, out_of, out_uf, v[i].f, v[i].of, v[i].uf);
      end
    end
  endtask

  task automatic test_overflow;
    vec_t v [3];
    v[0] = mk(0, 8'hFE, 8'hFF, 24'h800000, 0, 0, 32'h7F800000, 1, 0);
    v[1] = mk(1, 8'hFF, 8'hFF, 24'h800000, 0, 0, 32'hFF800000, 1, 0);
    v[2] = mk(0, 8'hFF, 8'h00, 24'hFFFFFF, 0, 0, 32'h7F800000, 1, 0);
    foreach (v[i]) begin
      send(v[i]);
      checks++;
      if (out_valid !== 1'b1 || {out_f, out_of, out_uf} !== {v[i].f, v[i].of, v[i].uf}) begin
        errors++;
        $display("FAIL overflow[%0d]: got valid=%b f=%h of=%b uf=%b, expected valid=1 f=%h of=%b uf=%b", i, out_valid, out_f, out_of, out_uf, v[i].f, v[i].of, v[i].uf);
      end
    end
  endtask

  task automatic test_underflow;
    vec_t v [4];
    v[0] = mk(0, 8'h02, 8'h05, 24'h800000, 0, 0, SUB ? 32'h00080000 : 32'h00000000, 0, 1);
    v[1] = mk(1, 8'h03, 8'h03, 24'h800000, 0, 0, SUB ? 32'h80400000 : 32'h80000000, 0, 1);
    v[2] = mk(1, 8'h00, 8'h16, 24'h800000, 0, 0, SUB ? 32'h80000001 : 32'h80000000, 0, 1);
    v[3] = mk(1, 8'h00, 8'h1E, 24'h800000, 0, 0, SUB ? 32'h00000000 : 32'h80000000, 0, 1);
    foreach (v[i]) begin
      send(v[i]);
      checks++;
      if (out_valid !== 1'b1 || {out_f, out_of, out_uf} !== {v[i].f, v[i].of, v[i].uf}) begin
        errors++;
        $display("FAIL underflow[%0d]: got valid=%b f=%h of=%b uf=%b, expected valid=1 f=%h of=%b uf=%b", i, out_valid, out_f, out_of, out_uf, v[i].f, v[i].of, v[i].uf);
      end
    end
  endtask

  task automatic test_back_to_back;
    int sent = 0, got = 0, stalls = 0, first_low = -1;
    logic [31:0] ef;
    in_valid = 0; out_ready = 1; in_nan = 0; in_inf = 0; in_sign = 0; in_num = 0;
    repeat (2) @(negedge clk);
    for (int c = 0; c < 30 && got < 4; c++) begin
      out_ready = (c >= 5);
      in_valid = (sent < 4);
      in_exp = 8'h10 + 8'(sent);
      in_res = 24'h800000 | 24'(sent);
      #1;
      if (out_valid) begin
        ef = {1'b0, 8'h10 + 8'(got), 23'(got)};
        checks++;
        if (out_f !== ef || out_of !== 1'b0 || out_uf !== 1'b0) begin
          errors++;
          $display("FAIL b2b_beat%0d cycle%0d: got f=%h of=%b uf=%b, expected f=%h of=0 uf=0", got, c, out_f, out_of, out_uf, ef);
        end
        if (!out_ready) stalls++;
      end
      if (!in_ready && first_low < 0) first_low = sent;
      if (out_valid && out_ready) got++;
      if (in_valid && in_ready) sent++;
      @(negedge clk);
    end
    in_valid = 0;
    checks++;
    if (got != 4 || sent != 4) begin
      errors++;
      $display("FAIL b2b_count: got emitted=%0d accepted=%0d, expected 4 and 4", got, sent);
    end
    checks++;
    if (first_low != 2) begin
      errors++;
      $display("FAIL b2b_in_ready: got in_ready low after %0d beats, expected 2", first_low);
    end
    checks++;
    if (stalls != 3) begin
      errors++;
      $display("FAIL b2b_stall: got %0d held cycles, expected 3", stalls);
    end
  endtask

  task automatic test_reset_midstream;
    in_sign = 0; in_exp = 8'h40; in_num = 0; in_res = 24'h800000; in_nan = 0; in_inf = 0;
    out_ready = 0; in_valid = 1;
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (out_valid !== 1'b1 || out_f !== 32'h20000000) begin
      errors++;
      $display("FAIL midrst_pre: got valid=%b f=%h, expected valid=1 f=20000000", out_valid, out_f);
    end
    rst_n = 0;
    #1;
    checks++;
    if ({out_valid, out_f, out_of, out_uf} !== 35'h0) begin
      errors++;
      $display("FAIL midrst_async: got valid=%b f=%h of=%b uf=%b, expected all 0", out_valid, out_f, out_of, out_uf);
    end
    in_valid = 0;
    @(negedge clk) rst_n = 1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrst_in_ready: got %b, expected 1", in_ready);
    end
    out_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_discard: got out_valid=%b, expected 0", out_valid);
    end
  endtask

  initial begin
    test_reset;
    test_normal;
    test_special;
    test_overflow;
    test_underflow;
    test_back_to_back;
    test_reset_midstream;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion before 200000ns");
    $fatal(1, "timeout");
  end
endmodule
